// File: rtl/truth_table_sweeper_if.sv
// Stimulus/capture bundle between the sweeper and its circuit under test.
// The sweeper drives the vector and results; the CUT side supplies f and start.
interface truth_table_sweeper_if;
  logic        start;
  logic        w, x, y, z;
  logic        f;
  logic        busy;
  logic        done;
  logic        results_valid;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic        pass;

  modport slave (
    input  start, f,
    output w, x, y, z, busy, done, results_valid,
           table_out, mismatch_count, first_fail_idx, pass
  );

  modport master (
    output start, f,
    input  w, x, y, z, busy, done, results_valid,
           table_out, mismatch_count, first_fail_idx, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input CUT through all 16 codes, holding each HOLD_CYCLES cycles,
// captures f into a truth table and scores it against EXPECTED.
module truth_table_sweeper #(
  parameter int          HOLD_CYCLES = 20,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [9:0] HOLD_LAST = 10'(HOLD_CYCLES - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [9:0]  hold_cnt;
  logic        busy, done, results_valid, pass;
  logic [15:0] table_q;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail_idx;
  logic        miss;

  assign miss = bus.f ^ EXPECTED[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      hold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      results_valid  <= 1'b0;
      pass           <= 1'b0;
      table_q        <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= SWEEP;
            idx            <= '0;
            hold_cnt       <= '0;
            busy           <= 1'b1;
            results_valid  <= 1'b0;
            pass           <= 1'b0;
            table_q        <= '0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
          end
        end
        SWEEP: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt     <= '0;
            table_q[idx] <= bus.f;
            if (miss) begin
              mismatch_count <= mismatch_count + 5'd1;
              if (mismatch_count == 5'd0) first_fail_idx <= idx;
            end
            if (idx == 4'd15) begin
              // pass is resolved here so it lands together with results_valid
              state         <= DONE;
              idx           <= '0;
              busy          <= 1'b0;
              done          <= 1'b1;
              results_valid <= 1'b1;
              pass          <= (mismatch_count == 5'd0) && !miss;
            end else begin
              idx <= idx + 4'd1;
            end
          end else begin
            hold_cnt <= hold_cnt + 10'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // idx is 0 whenever not sweeping, so the vector needs no extra gating
  assign {bus.w, bus.x, bus.y, bus.z} = idx;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.results_valid  = results_valid;
  assign bus.table_out      = table_q;
  assign bus.mismatch_count = mismatch_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.pass           = pass;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Three sweepers (H = 20, 3, 1) driven by truth-table CUTs; each sweep is
// scored against a table-level model of vector timing and result scoring.
module tb_truth_table_sweeper;
  localparam int          HS [3] = '{20, 3, 1};
  localparam logic [15:0] EX [3] = '{16'hF888, 16'h6996, 16'hAAAA};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [3];
  logic [15:0] tt      [3];
  wire  [3:0]  vec_v   [3];
  wire         busy_v  [3];
  wire         done_v  [3];
  wire         rv_v    [3];
  wire         pass_v  [3];
  wire  [15:0] tab_v   [3];
  wire  [4:0]  mc_v    [3];
  wire  [3:0]  ffi_v   [3];

  int n_tests = 0;
  int n_fail  = 0;

  truth_table_sweeper_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    truth_table_sweeper #(.HOLD_CYCLES(HS[g]), .EXPECTED(EX[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
    assign vec_v[g]     = {bus[g].w, bus[g].x, bus[g].y, bus[g].z};
    assign bus[g].f     = tt[g][vec_v[g]];
    assign bus[g].start = start_v[g];
    assign busy_v[g]    = bus[g].busy;
    assign done_v[g]    = bus[g].done;
    assign rv_v[g]      = bus[g].results_valid;
    assign pass_v[g]    = bus[g].pass;
    assign tab_v[g]     = bus[g].table_out;
    assign mc_v[g]      = bus[g].mismatch_count;
    assign ffi_v[g]     = bus[g].first_fail_idx;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input int g, input string tag);
    chk({tag, "_vec"},  vec_v[g],  0);
    chk({tag, "_busy"}, busy_v[g], 0);
    chk({tag, "_done"}, done_v[g], 0);
    chk({tag, "_rv"},   rv_v[g],   0);
    chk({tag, "_pass"}, pass_v[g], 0);
    chk({tag, "_tab"},  tab_v[g],  0);
    chk({tag, "_mc"},   mc_v[g],   0);
    chk({tag, "_ffi"},  ffi_v[g],  0);
  endtask

  // mode 0: single start pulse; 1: random start noise mid-sweep; 2: start held
  task automatic run_sweep(input int g, input logic [15:0] f_tt, input int mode);
    int          h = HS[g];
    logic [15:0] diff = f_tt ^ EX[g];
    int          exp_mc = $countones(diff);
    int          exp_ffi = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) exp_ffi = i;
    tt[g] = f_tt;
    @(negedge clk);
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    if (mode != 2) start_v[g] = 1'b0;
    chk("acc_rv",  rv_v[g],  0);
    chk("acc_tab", tab_v[g], 0);
    chk("acc_mc",  mc_v[g],  0);
    chk("acc_ffi", ffi_v[g], 0);
    chk("acc_pass", pass_v[g], 0);
    for (int k = 0; k < 16 * h; k++) begin
      chk("vec",  vec_v[g],  k / h);
      chk("busy", busy_v[g], 1);
      chk("done_early", done_v[g], 0);
      if (mode == 1) start_v[g] = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    if (mode != 2) start_v[g] = 1'b0;
    chk("done",    done_v[g], 1);
    chk("busy_end", busy_v[g], 0);
    chk("rv",      rv_v[g],   1);
    chk("vec_end", vec_v[g],  0);
    chk("table",   tab_v[g],  f_tt);
    chk("mc",      mc_v[g],   exp_mc);
    chk("ffi",     ffi_v[g],  exp_ffi);
    chk("pass",    pass_v[g], exp_mc == 0);
    @(posedge clk);
    #1;
    chk("done_1cyc", done_v[g], 0);
    chk("idle_busy", busy_v[g], 0);
    chk("hold_rv",   rv_v[g],   1);
    chk("hold_tab",  tab_v[g],  f_tt);
  endtask

  initial begin
    logic [15:0] maj;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      tt[i] = '0;
    end
    #1;
    for (int i = 0; i < 3; i++) chk_zero(i, "rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // majority-style and stuck-at-0 CUTs on the H=20 sweeper
    maj = '0;
    for (int i = 0; i < 16; i++) maj[i] = (i[3] & i[2]) | (i[1] & i[0]);
    run_sweep(0, maj, 0);
    run_sweep(0, 16'h0000, 0);

    // H=3: random CUT with start noise, then back-to-back with start held
    run_sweep(1, 16'($urandom), 1);
    run_sweep(1, 16'($urandom), 2);
    run_sweep(1, 16'($urandom), 2);
    run_sweep(1, 16'h6996, 0);

    // H=1 with f = z
    run_sweep(2, 16'hAAAA, 0);
    for (int n = 0; n < 4; n++) run_sweep(2, 16'($urandom), n % 2);

    // reset mid-sweep at vector 7
    tt[0] = 16'($urandom);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (7 * 20 + 5) @(posedge clk);
    #1;
    chk("mid_vec", vec_v[0], 7);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero(0, "arst");
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("arst_no_done", done_v[0], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", busy_v[0], 0);
    end
    run_sweep(0, maj, 0);
    run_sweep(0, 16'($urandom), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
